// File: rtl/eco_equiv_sweep_ctrl_if.sv
// Bus between the ECO sweep controller, its test controller and the golden/revised netlist pair.
// The master side drives the control and netlist outputs. The slave side is the sweep controller.
interface eco_equiv_sweep_ctrl_if #(
  parameter int AW = 5,
  parameter int BW = 5,
  parameter int YW = 3
);
  logic              start;
  logic              abort;
  logic              stop_on_fail;
  logic [AW-1:0]     drive_a;
  logic [BW-1:0]     drive_b;
  logic [YW-1:0]     y_gold;
  logic [YW-1:0]     y_rev;
  logic              busy;
  logic              done;
  logic              pass;
  logic [AW+BW:0]    mismatch_cnt;
  logic              fail_valid;
  logic [AW-1:0]     first_fail_a;
  logic [BW-1:0]     first_fail_b;
  logic [YW-1:0]     first_fail_diff;

  modport master (
    output start, abort, stop_on_fail, y_gold, y_rev,
    input  drive_a, drive_b, busy, done, pass, mismatch_cnt,
           fail_valid, first_fail_a, first_fail_b, first_fail_diff
  );

  modport slave (
    input  start, abort, stop_on_fail, y_gold, y_rev,
    output drive_a, drive_b, busy, done, pass, mismatch_cnt,
           fail_valid, first_fail_a, first_fail_b, first_fail_diff
  );
endinterface

// File: rtl/eco_equiv_sweep_ctrl.sv
// Exhaustive golden-vs-revised netlist sweep. It walks {B,A} from 0 to all-ones, waits SETTLE cycles
// per vector, then compares Y and accumulates the mismatch count and the first-failure details.
module eco_equiv_sweep_ctrl #(
  parameter int AW     = 5,
  parameter int BW     = 5,
  parameter int YW     = 3,
  parameter int SETTLE = 1
) (
  input logic                    clk,
  input logic                    rst_n,
  eco_equiv_sweep_ctrl_if.slave  bus
);
  localparam int IW = AW + BW;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  localparam logic [3:0]    SETTLE_V = 4'(SETTLE);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [IW-1:0] IDX_LAST = '1;
  localparam logic [IW:0]   CNT_ONE  = (IW+1)'(1);

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [3:0]    wait_q, wait_d;
  logic          stop_q, stop_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [IW:0]   cnt_q, cnt_d;
  logic          fv_q, fv_d;
  logic [AW-1:0] ffa_q, ffa_d;
  logic [BW-1:0] ffb_q, ffb_d;
  logic [YW-1:0] ffd_q, ffd_d;

  logic [YW-1:0] diff;
  logic          is_last;

  assign diff    = bus.y_gold ^ bus.y_rev;
  assign is_last = (idx_q == IDX_LAST);

  // Abort outranks the compare, so an aborting CHECK cycle neither counts nor captures.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    stop_d  = stop_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    cnt_d   = cnt_q;
    fv_d    = fv_q;
    ffa_d   = ffa_q;
    ffb_d   = ffb_q;
    ffd_d   = ffd_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          idx_d   = '0;
          wait_d  = SETTLE_V;
          cnt_d   = '0;
          fv_d    = 1'b0;
          ffa_d   = '0;
          ffb_d   = '0;
          ffd_d   = '0;
          pass_d  = 1'b0;
          stop_d  = bus.stop_on_fail;
          busy_d  = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
        end else if (wait_q == 4'd0) begin
          state_d = ST_CHECK;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      ST_CHECK: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
        end else begin
          if (diff != '0) begin
            cnt_d = cnt_q + CNT_ONE;
            if (!fv_q) begin
              fv_d  = 1'b1;
              ffa_d = idx_q[AW-1:0];
              ffb_d = idx_q[IW-1:AW];
              ffd_d = diff;
            end
          end
          if (is_last || (stop_q && (diff != '0))) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (cnt_d == '0);
          end else begin
            idx_d   = idx_q + IDX_ONE;
            wait_d  = SETTLE_V;
            state_d = ST_WAIT;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      wait_q  <= '0;
      stop_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      cnt_q   <= '0;
      fv_q    <= 1'b0;
      ffa_q   <= '0;
      ffb_q   <= '0;
      ffd_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      stop_q  <= stop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      cnt_q   <= cnt_d;
      fv_q    <= fv_d;
      ffa_q   <= ffa_d;
      ffb_q   <= ffb_d;
      ffd_q   <= ffd_d;
    end
  end

  // The vector index register itself drives both netlists, so the drives hold whenever idx holds.
  assign bus.drive_a         = idx_q[AW-1:0];
  assign bus.drive_b         = idx_q[IW-1:AW];
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.pass            = pass_q;
  assign bus.mismatch_cnt    = cnt_q;
  assign bus.fail_valid      = fv_q;
  assign bus.first_fail_a    = ffa_q;
  assign bus.first_fail_b    = ffb_q;
  assign bus.first_fail_diff = ffd_q;

endmodule

// File: tb/tb_eco_equiv_sweep_ctrl.sv
// Randomized self-checking bench for eco_equiv_sweep_ctrl with SETTLE = 1, 0 and 3 instances.
// The golden and revised netlists are modelled behaviourally, and the expected results come from a per-vector walk.
module tb_eco_equiv_sweep_ctrl;
  localparam int AW = 5;
  localparam int BW = 5;
  localparam int YW = 3;
  localparam int N  = 1 << (AW + BW);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int   vecs = 0;
  int   miscompares = 0;

  int   sel = 0;
  logic startReq = 1'b0;
  logic abortReq = 1'b0;
  logic stopReq  = 1'b0;
  int   mode = 0;
  logic [YW-1:0] flipTab [N];

  eco_equiv_sweep_ctrl_if #(.AW(AW), .BW(BW), .YW(YW)) busS1 ();
  eco_equiv_sweep_ctrl_if #(.AW(AW), .BW(BW), .YW(YW)) busS0 ();
  eco_equiv_sweep_ctrl_if #(.AW(AW), .BW(BW), .YW(YW)) busS3 ();

  eco_equiv_sweep_ctrl #(.AW(AW), .BW(BW), .YW(YW), .SETTLE(1)) dutS1 (.clk(clk), .rst_n(rst_n), .bus(busS1.slave));
  eco_equiv_sweep_ctrl #(.AW(AW), .BW(BW), .YW(YW), .SETTLE(0)) dutS0 (.clk(clk), .rst_n(rst_n), .bus(busS0.slave));
  eco_equiv_sweep_ctrl #(.AW(AW), .BW(BW), .YW(YW), .SETTLE(3)) dutS3 (.clk(clk), .rst_n(rst_n), .bus(busS3.slave));

  function automatic logic [YW-1:0] goldY(logic [AW-1:0] a, logic [BW-1:0] b);
    logic [AW-1:0] s;
    s = a + (b << 1);
    return s[YW-1:0] ^ {b[4], a[4], a[0]};
  endfunction

  // Revised netlist = golden output XOR a mode-dependent flip pattern.
  always_comb begin
    busS1.start        = startReq && (sel == 0);
    busS0.start        = startReq && (sel == 1);
    busS3.start        = startReq && (sel == 2);
    busS1.abort        = abortReq && (sel == 0);
    busS0.abort        = abortReq && (sel == 1);
    busS3.abort        = abortReq && (sel == 2);
    busS1.stop_on_fail = stopReq;
    busS0.stop_on_fail = stopReq;
    busS3.stop_on_fail = stopReq;
    busS1.y_gold = goldY(busS1.drive_a, busS1.drive_b);
    busS0.y_gold = goldY(busS0.drive_a, busS0.drive_b);
    busS3.y_gold = goldY(busS3.drive_a, busS3.drive_b);
    busS1.y_rev = busS1.y_gold ^ ((mode == 1) ? {2'b00, busS1.drive_a[1] & busS1.drive_b[1]} :
                                  (mode == 2) ? flipTab[{busS1.drive_b, busS1.drive_a}] : 3'b000);
    busS0.y_rev = busS0.y_gold ^ ((mode == 1) ? {2'b00, busS0.drive_a[1] & busS0.drive_b[1]} :
                                  (mode == 2) ? flipTab[{busS0.drive_b, busS0.drive_a}] : 3'b000);
    busS3.y_rev = busS3.y_gold ^ ((mode == 1) ? {2'b00, busS3.drive_a[1] & busS3.drive_b[1]} :
                                  (mode == 2) ? flipTab[{busS3.drive_b, busS3.drive_a}] : 3'b000);
  end

  logic              oBusy, oDone, oPass, oFv;
  logic [AW+BW:0]    oCnt;
  logic [AW-1:0]     oA, oFa;
  logic [BW-1:0]     oB, oFb;
  logic [YW-1:0]     oFd;

  always_comb begin
    case (sel)
      1: begin
        oBusy = busS0.busy; oDone = busS0.done; oPass = busS0.pass; oFv = busS0.fail_valid;
        oCnt = busS0.mismatch_cnt; oA = busS0.drive_a; oB = busS0.drive_b;
        oFa = busS0.first_fail_a; oFb = busS0.first_fail_b; oFd = busS0.first_fail_diff;
      end
      2: begin
        oBusy = busS3.busy; oDone = busS3.done; oPass = busS3.pass; oFv = busS3.fail_valid;
        oCnt = busS3.mismatch_cnt; oA = busS3.drive_a; oB = busS3.drive_b;
        oFa = busS3.first_fail_a; oFb = busS3.first_fail_b; oFd = busS3.first_fail_diff;
      end
      default: begin
        oBusy = busS1.busy; oDone = busS1.done; oPass = busS1.pass; oFv = busS1.fail_valid;
        oCnt = busS1.mismatch_cnt; oA = busS1.drive_a; oB = busS1.drive_b;
        oFa = busS1.first_fail_a; oFb = busS1.first_fail_b; oFd = busS1.first_fail_diff;
      end
    endcase
  end

  task automatic checkOutput(input string tag, input int obs, input int exp);
    vecs++;
    if (obs != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int settleOf(input int s);
    return (s == 1) ? 0 : (s == 2) ? 3 : 1;
  endfunction

  // Spec-level flip rule per vector index (A = low bits).
  function automatic int expFlip(input int idx);
    int a, b;
    a = idx % 32;
    b = idx / 32;
    if (mode == 1) return (((a / 2) % 2 == 1) && ((b / 2) % 2 == 1)) ? 1 : 0;
    if (mode == 2) return int'(flipTab[idx]);
    return 0;
  endfunction

  int expCnt, expFv, expFa, expFb, expFd, expLast, expLen, expPass, expDrive;

  task automatic computeExpected(input int s, input bit stopFlag, input int abortAt);
    int limit, d;
    expCnt = 0; expFv = 0; expFa = 0; expFb = 0; expFd = 0;
    expLast = N - 1;
    limit = (abortAt >= 0) ? (abortAt - 1) / (settleOf(s) + 2) : N;
    for (int i = 0; i < limit; i++) begin
      d = expFlip(i);
      if (d != 0) begin
        expCnt++;
        if (expFv == 0) begin
          expFv = 1; expFa = i % 32; expFb = i / 32; expFd = d;
        end
        if (stopFlag && abortAt < 0) begin
          expLast = i;
          break;
        end
      end
    end
    expLen   = (settleOf(s) + 2) * (expLast + 1);
    expPass  = (abortAt < 0 && expCnt == 0) ? 1 : 0;
    expDrive = (abortAt >= 0) ? limit : expLast;
  endtask

  int obsBusyCycles, obsDoneAt, obsDoneCount, obsChanges, obsViol, obsCntK0;

  task automatic applyStimulus(input int s, input bit stopFlag, input int abortAt);
    int budget, cur, prevIdx, st;
    st = settleOf(s) + 2;
    sel = s;
    stopReq = stopFlag;
    @(negedge clk);
    startReq = 1'b1;
    @(posedge clk);
    #1 startReq = 1'b0;
    budget = st * N + 20;
    obsBusyCycles = 0; obsDoneAt = -1; obsDoneCount = 0; obsChanges = 0; obsViol = 0;
    obsCntK0 = -1;
    prevIdx = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (k == 0) obsCntK0 = int'(oCnt);
      if (oBusy) obsBusyCycles++;
      if (oDone) begin
        obsDoneCount++;
        if (obsDoneAt < 0) obsDoneAt = k;
      end
      cur = int'({oB, oA});
      if (cur != prevIdx) begin
        obsChanges++;
        if (k % st != 0) obsViol++;
      end
      prevIdx = cur;
      if (abortAt >= 0 && k == abortAt - 1) abortReq = 1'b1;
      if (k == abortAt) abortReq = 1'b0;
      if (obsDoneAt >= 0 && k >= obsDoneAt + 2) break;
      if (abortAt >= 0 && k >= abortAt + 2) break;
    end
    abortReq = 1'b0;
  endtask

  task automatic runAndCheck(input string name, input int s, input bit stopFlag);
    computeExpected(s, stopFlag, -1);
    applyStimulus(s, stopFlag, -1);
    checkOutput({name, ".cntAtStart"}, obsCntK0, 0);
    checkOutput({name, ".busyCycles"}, obsBusyCycles, expLen);
    checkOutput({name, ".doneAt"}, obsDoneAt, expLen);
    checkOutput({name, ".doneCount"}, obsDoneCount, 1);
    checkOutput({name, ".pass"}, int'(oPass), expPass);
    checkOutput({name, ".mismatchCnt"}, int'(oCnt), expCnt);
    checkOutput({name, ".failValid"}, int'(oFv), expFv);
    checkOutput({name, ".firstFailA"}, int'(oFa), expFa);
    checkOutput({name, ".firstFailB"}, int'(oFb), expFb);
    checkOutput({name, ".firstFailDiff"}, int'(oFd), expFd);
    checkOutput({name, ".driveHeld"}, int'({oB, oA}), expDrive);
    checkOutput({name, ".driveChanges"}, obsChanges, expLast);
    checkOutput({name, ".driveOffEdge"}, obsViol, 0);
  endtask

  task automatic fillTable(input int oneIn);
    for (int i = 0; i < N; i++)
      flipTab[i] = ($urandom_range(0, oneIn - 1) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, ".busy"}, int'(oBusy), 0);
    checkOutput({name, ".done"}, int'(oDone), 0);
    checkOutput({name, ".pass"}, int'(oPass), 0);
    checkOutput({name, ".mismatchCnt"}, int'(oCnt), 0);
    checkOutput({name, ".failValid"}, int'(oFv), 0);
    checkOutput({name, ".drive"}, int'({oB, oA}), 0);
    checkOutput({name, ".firstFail"}, int'({oFa, oFb, oFd}), 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) flipTab[i] = 3'b000;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkAllZero("idleAfterReset");

    mode = 0; runAndCheck("identical", 0, 1'b0);
    mode = 1; runAndCheck("flipA1B1", 0, 1'b0);
    checkOutput("flipA1B1.specCnt", int'(oCnt), 256);
    mode = 1; runAndCheck("stopOnFail", 0, 1'b1);
    checkOutput("stopOnFail.specIdx", int'({oB, oA}), 66);
    mode = 0; runAndCheck("settle0", 1, 1'b0);
    checkOutput("settle0.specLen", obsBusyCycles, 2048);
    mode = 0; runAndCheck("settle3", 2, 1'b0);
    checkOutput("settle3.specLen", obsBusyCycles, 5120);

    // Abort at edge 100 with a dense random mismatch table, then restart.
    mode = 2; fillTable(8);
    computeExpected(0, 1'b0, 100);
    applyStimulus(0, 1'b0, 100);
    checkOutput("abort.doneCount", obsDoneCount, 0);
    checkOutput("abort.busyCycles", obsBusyCycles, 100);
    checkOutput("abort.pass", int'(oPass), 0);
    checkOutput("abort.partialCnt", int'(oCnt), expCnt);
    checkOutput("abort.failValid", int'(oFv), expFv);
    checkOutput("abort.firstFailA", int'(oFa), expFa);
    checkOutput("abort.firstFailB", int'(oFb), expFb);
    checkOutput("abort.firstFailDiff", int'(oFd), expFd);
    checkOutput("abort.driveHeld", int'({oB, oA}), expDrive);
    repeat (2) @(negedge clk);
    checkOutput("abort.cntHolds", int'(oCnt), expCnt);
    runAndCheck("afterAbort", 0, 1'b0);

    // Short reset pulse mid-sweep.
    mode = 1;
    computeExpected(0, 1'b0, 400);
    sel = 0; stopReq = 1'b0;
    @(negedge clk); startReq = 1'b1;
    @(posedge clk); #1 startReq = 1'b0;
    repeat (400) @(negedge clk);
    checkOutput("preReset.cnt", int'(oCnt), expCnt);
    #2 rst_n = 1'b0;
    #1 checkAllZero("asyncReset");
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("postReset.idleBusy", int'(oBusy), 0);
    checkOutput("postReset.idleDrive", int'({oB, oA}), 0);
    runAndCheck("postReset", 0, 1'b0);

    for (int r = 0; r < 3; r++) begin
      mode = 2;
      fillTable(8 << $urandom_range(0, 4));
      runAndCheck($sformatf("random%0d", r), int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end
endmodule
